// File: rtl/approx_wallace_final_accumulator.sv
// Exact carry-propagate add of the tree's sum/carry rows, accumulated into a wide register.
// Two-stage pipe (capture, resolve+accumulate); the result is held on a valid/ready port until it is taken.
module approx_wallace_final_accumulator #(
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          sum_vec,
  input  logic [15:0]          carry_vec,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic [7:0]           count_o,
  output logic                 overflow_o,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {S_ACC, S_DONE} state_t;

  state_t               r_state;
  logic                 r_a_valid;
  logic                 r_a_last;
  logic [15:0]          r_a_sum;
  logic [15:0]          r_a_carry;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [7:0]           r_count;
  logic                 r_ovf;

  logic                 w_accept;
  logic [16:0]          w_term;
  logic [ACC_WIDTH:0]   w_acc_next;

  // A pending last in stage A must stop further products joining this result.
  assign in_ready   = (r_state == S_ACC) && !(r_a_valid && r_a_last);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;

  assign w_term     = {1'b0, r_a_sum} + {1'b0, r_a_carry};
  assign w_acc_next = {1'b0, r_acc} + {{(ACC_WIDTH - 16){1'b0}}, w_term};

  assign acc_o      = r_acc;
  assign count_o    = r_count;
  assign overflow_o = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_sum   <= '0;
      r_a_carry <= '0;
    end else begin
      r_a_valid <= w_accept;
      if (w_accept) begin
        r_a_last  <= in_last;
        r_a_sum   <= sum_vec;
        r_a_carry <= carry_vec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (r_a_valid) begin
            r_acc   <= w_acc_next[ACC_WIDTH-1:0];
            r_ovf   <= r_ovf | w_acc_next[ACC_WIDTH];
            r_count <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
            if (r_a_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_ACC;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: doc/approx_wallace_final_accumulator.md
# approx_wallace_final_accumulator

Final carry-propagate and accumulation stage for the approximate 8-bit Wallace tree multiplier. It consumes the redundant sum/carry vectors left by the last reduction layer, resolves them with one exact carry-propagate add and accumulates successive products into a wide register. When the producer flags the last product it presents the dot-product result on a valid/ready output port. Accumulation is exact; all approximation error originates upstream in the tree.

## Interface
- ACC_WIDTH, 24: accumulator and result width; must be ≥ 17.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; **one clock; reset is asynchronous and active-high.**
- sum_vec  in  16  sum row from the final reduction layer, weights 2^0..2^15.
- carry_vec  in  16  carry row from the final reduction layer, already aligned to its weight, weights 2^0..2^15.
- in_valid  in  1  sum_vec/carry_vec/in_last are valid.
- in_last  in  1  this product closes the current accumulation.
- in_ready  out  1  block accepts input this cycle.
- acc_o  out  ACC_WIDTH  accumulated result; meaningful when out_valid.
- count_o  out  8  number of products in acc_o, saturating at 255.
- overflow_o  out  1  sticky; the accumulator wrapped during this accumulation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.

## Operation
- **Input handshake.** A product is accepted on a rising edge where in_valid && in_ready.
- **Stage A (capture).** Registers sum_vec, carry_vec and in_last, and sets a_valid. a_valid clears when no product is accepted.
- **Stage B (resolve and accumulate).** When a_valid is set:
  - term = zero-extend(a_sum) + zero-extend(a_carry), 17 bits, exact.
  - acc <= (acc + term) mod 2^ACC_WIDTH.
  - The ACC_WIDTH carry-out ORs into overflow_o.
  - count_o increments, saturating at 255.
- **States.**
  - S_ACC: accumulating.
  - S_DONE: result held.
- **Transitions.**
  - S_ACC -> S_DONE: on the edge where stage B consumes an entry with a_last=1. That entry's term is included in acc_o.
  - S_DONE -> S_ACC: on the edge where out_valid && out_ready. On the same edge, acc, count_o and overflow_o clear to 0.
- **Input gating.** in_ready = (state==S_ACC) && !(a_valid && a_last). Products after a last are never merged into the finished result.
- **Output.** out_valid = (state==S_DONE). acc_o, count_o and overflow_o stay stable while out_valid is high and out_ready is low.
- **Output handshake.** out_ready while out_valid is low is ignored.
- **in_last handling.** in_last with in_valid low is ignored.
- **Single-product accumulation.** in_last on the first product is legal: count_o=1.

## Timing
- **Reset values (asynchronous).** Applied immediately on rst assertion, independent of clk:
  - state=S_ACC, a_valid=0, acc_o=0, count_o=0, overflow_o=0, out_valid=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-accumulation or mid-hold discards everything, with no partial output.
- **Throughput.** One product per cycle in S_ACC while no last is pending.
- **Latency.**
  - Product accepted at edge N is in acc at edge N+1.
  - A last accepted at edge N gives out_valid=1 after edge N+1.
- **Minimum turnaround.** Last accepted at edge N, out_ready held high:
  - Result handshakes at edge N+2.
  - in_ready is 0 from after edge N until after edge N+2.
  - The next product can be accepted at edge N+3 at the earliest.
- **Combinational paths.** in_ready and out_valid are functions of registers only; there are no combinational input-to-output paths.
- **Critical path.** The 17-bit add followed by the ACC_WIDTH add in stage B; stage A exists to isolate the tree's output timing.

## Test plan
- **Reset.** Assert rst mid-stream with acc nonzero -> all outputs 0 immediately, without waiting for a clock edge; in_ready=1 after release.
- **Single product.** Sum 0x00F0, carry 0x0010, in_last=1 -> out_valid two edges after accept; acc_o=0x000100, count_o=1, overflow_o=0.
- **Streaming.** Four back-to-back products, each sum 0xFFFF and carry 0x0001, the last flagged -> acc_o=0x040000, count_o=4.
- **Backpressure.**
  - Hold out_ready=0 for 5 cycles after out_valid -> outputs stable; in_ready=0 throughout; in_valid pulses are not accepted.
  - Release out_ready -> acc_o, count_o and overflow_o read 0 on the next cycle.
- **Overflow (ACC_WIDTH=17).** Products of 0xFFFF+0xFFFF, then 0x0004 last -> acc_o=(0x1FFFE+4) mod 2^17=0x00002, overflow_o=1; a following accumulation starts with overflow_o=0.
- **Gating around last.**
  - Present in_valid continuously across an in_last -> the product after the last is not accepted until after the result handshake, and it lands in the new accumulation.
  - 300 products -> count_o saturates at 255.
